// File: rtl/axi4_slv_mem_if.sv
// AXI4 bus bundle between a master and the axi4_slv_mem slave; no logic, no latency.
// Valid/ready handshakes on every channel; the slave only asserts ready in the states that can take a transfer.
interface axi4_slv_mem_if #(
    parameter int DW  = 64,
    parameter int IDW = 8
);
    logic [IDW-1:0]  AWID;
    logic [31:0]     AWADDR;
    logic [7:0]      AWLEN;
    logic [2:0]      AWSIZE;
    logic [1:0]      AWBURST;
    logic            AWVALID;
    logic            AWREADY;
    logic [DW-1:0]   WDATA;
    logic [DW/8-1:0] WSTRB;
    logic            WLAST;
    logic            WVALID;
    logic            WREADY;
    logic [IDW-1:0]  BID;
    logic [1:0]      BRESP;
    logic            BVALID;
    logic            BREADY;
    logic [IDW-1:0]  ARID;
    logic [31:0]     ARADDR;
    logic [7:0]      ARLEN;
    logic [2:0]      ARSIZE;
    logic [1:0]      ARBURST;
    logic            ARVALID;
    logic            ARREADY;
    logic [IDW-1:0]  RID;
    logic [DW-1:0]   RDATA;
    logic [1:0]      RRESP;
    logic            RLAST;
    logic            RVALID;
    logic            RREADY;

    modport slave (
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );

    modport master (
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );
endinterface

// File: rtl/axi4_slv_mem.sv
// AXI4 slave SRAM with independent write and read engines; one W beat per cycle, one R beat per two cycles.
// Bursts that fail range/size/burst checks are consumed in full but answered with SLVERR and never touch memory.
module axi4_slv_mem #(
    parameter int          DW   = 64,
    parameter int          AW   = 14,
    parameter int          IDW  = 8,
    parameter logic [31:0] BASE = 32'h8000_0000
) (
    input  logic               CLK,
    input  logic               RSTn,
    axi4_slv_mem_if.slave      MEM
);
    localparam int          B     = DW / 8;
    localparam int          LB    = $clog2(B);
    localparam logic [31:0] BMASK = 32'(B - 1);
    localparam logic [32:0] LIMIT = {1'b0, BASE} + (33'd1 << (AW + LB));

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wst_e;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rst_e;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

    function automatic logic [31:0] wrap_mask(input logic [7:0] len);
        return ((32'(len) + 32'd1) << LB) - 32'd1;
    endfunction

    // Illegal WRAP lengths and the reserved encoding walk the address like INCR.
    function automatic logic [1:0] eff_burst(input logic [1:0] burst, input logic [7:0] len);
        if (burst == 2'b00) return 2'b00;
        if (burst == 2'b10 && wrap_len_ok(len)) return 2'b10;
        return 2'b01;
    endfunction

    // Whole-burst check at the address handshake, so no beat is written before an error is known.
    function automatic logic burst_err(input logic [31:0] a, input logic [7:0] len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic [32:0] lo;
        logic [32:0] hi;
        logic [31:0] m;
        m = wrap_mask(len);
        case (eff_burst(burst, len))
            2'b00:   begin lo = {1'b0, a};      hi = {1'b0, a | BMASK}; end
            2'b10:   begin lo = {1'b0, a & ~m}; hi = lo + {1'b0, m}; end
            default: begin
                lo = {1'b0, a};
                hi = {1'b0, a & ~BMASK} + ({25'd0, len} << LB) + {1'b0, BMASK};
            end
        endcase
        return (size != 3'(LB)) || (burst == 2'b11) || (burst == 2'b10 && !wrap_len_ok(len))
            || (lo < {1'b0, BASE}) || (hi >= LIMIT);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst,
                                              input logic [7:0] len);
        logic [31:0] m;
        m = wrap_mask(len);
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~m) | (((a & ~BMASK) + 32'(B)) & m);
            default: return (a & ~BMASK) + 32'(B);
        endcase
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
        return AW'((a - BASE) >> LB);
    endfunction

    logic [DW-1:0] mem_q [2**AW];
    logic          rdy_en_q;

    // ---------------- write engine ----------------
    wst_e           wst_q,   wst_d;
    logic [IDW-1:0] bid_q,   bid_d;
    logic [31:0]    waddr_q, waddr_d;
    logic [7:0]     wlen_q,  wlen_d;
    logic [7:0]     wcnt_q,  wcnt_d;
    logic [1:0]     wbur_q,  wbur_d;
    logic           werr_q,  werr_d;
    logic           mem_we;

    always_comb begin
        wst_d   = wst_q;
        bid_d   = bid_q;
        waddr_d = waddr_q;
        wlen_d  = wlen_q;
        wcnt_d  = wcnt_q;
        wbur_d  = wbur_q;
        werr_d  = werr_q;
        mem_we  = 1'b0;
        case (wst_q)
            W_IDLE: if (MEM.AWVALID && rdy_en_q) begin
                bid_d   = MEM.AWID;
                waddr_d = MEM.AWADDR;
                wlen_d  = MEM.AWLEN;
                wbur_d  = eff_burst(MEM.AWBURST, MEM.AWLEN);
                werr_d  = burst_err(MEM.AWADDR, MEM.AWLEN, MEM.AWSIZE, MEM.AWBURST);
                wcnt_d  = '0;
                wst_d   = W_DATA;
            end
            W_DATA: if (MEM.WVALID) begin
                mem_we  = !werr_q;
                wcnt_d  = wcnt_q + 8'd1;
                waddr_d = next_addr(waddr_q, wbur_q, wlen_q);
                if (MEM.WLAST || (wcnt_q == wlen_q)) begin
                    wst_d = W_RESP;
                    // WLAST disagreeing with AWLEN, early or missing, is a protocol error.
                    if (MEM.WLAST != (wcnt_q == wlen_q)) werr_d = 1'b1;
                end
            end
            W_RESP: if (MEM.BREADY) wst_d = W_IDLE;
            default: wst_d = W_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rdy_en_q <= 1'b0;
            wst_q    <= W_IDLE;
            bid_q    <= '0;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wcnt_q   <= '0;
            wbur_q   <= '0;
            werr_q   <= 1'b0;
        end else begin
            rdy_en_q <= 1'b1;
            wst_q    <= wst_d;
            bid_q    <= bid_d;
            waddr_q  <= waddr_d;
            wlen_q   <= wlen_d;
            wcnt_q   <= wcnt_d;
            wbur_q   <= wbur_d;
            werr_q   <= werr_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int i = 0; i < B; i++) begin
                if (MEM.WSTRB[i]) mem_q[word_idx(waddr_q)][i*8 +: 8] <= MEM.WDATA[i*8 +: 8];
            end
        end
    end

    assign MEM.AWREADY = (wst_q == W_IDLE) && rdy_en_q;
    assign MEM.WREADY  = (wst_q == W_DATA);
    assign MEM.BVALID  = (wst_q == W_RESP);
    assign MEM.BID     = bid_q;
    assign MEM.BRESP   = {werr_q, 1'b0};

    // ---------------- read engine ----------------
    rst_e           rst_q,   rst_d;
    logic [IDW-1:0] rid_q,   rid_d;
    logic [31:0]    raddr_q, raddr_d;
    logic [7:0]     rlen_q,  rlen_d;
    logic [7:0]     rcnt_q,  rcnt_d;
    logic [1:0]     rbur_q,  rbur_d;
    logic           rerr_q,  rerr_d;
    logic [DW-1:0]  rdata_q, rdata_d;
    logic           rlast_q, rlast_d;
    logic [1:0]     rresp_q, rresp_d;

    always_comb begin
        rst_d   = rst_q;
        rid_d   = rid_q;
        raddr_d = raddr_q;
        rlen_d  = rlen_q;
        rcnt_d  = rcnt_q;
        rbur_d  = rbur_q;
        rerr_d  = rerr_q;
        rdata_d = rdata_q;
        rlast_d = rlast_q;
        rresp_d = rresp_q;
        case (rst_q)
            R_IDLE: if (MEM.ARVALID && rdy_en_q) begin
                rid_d   = MEM.ARID;
                raddr_d = MEM.ARADDR;
                rlen_d  = MEM.ARLEN;
                rbur_d  = eff_burst(MEM.ARBURST, MEM.ARLEN);
                rerr_d  = burst_err(MEM.ARADDR, MEM.ARLEN, MEM.ARSIZE, MEM.ARBURST);
                rcnt_d  = '0;
                rst_d   = R_FETCH;
            end
            // The array read sees the value before any same-cycle write commits.
            R_FETCH: begin
                rdata_d = rerr_q ? '0 : mem_q[word_idx(raddr_q)];
                rlast_d = (rcnt_q == rlen_q);
                rresp_d = {rerr_q, 1'b0};
                rst_d   = R_DATA;
            end
            R_DATA: if (MEM.RREADY) begin
                if (rlast_q) begin
                    rlast_d = 1'b0;
                    rst_d   = R_IDLE;
                end else begin
                    raddr_d = next_addr(raddr_q, rbur_q, rlen_q);
                    rcnt_d  = rcnt_q + 8'd1;
                    rst_d   = R_FETCH;
                end
            end
            default: rst_d = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rst_q   <= R_IDLE;
            rid_q   <= '0;
            raddr_q <= '0;
            rlen_q  <= '0;
            rcnt_q  <= '0;
            rbur_q  <= '0;
            rerr_q  <= 1'b0;
            rdata_q <= '0;
            rlast_q <= 1'b0;
            rresp_q <= '0;
        end else begin
            rst_q   <= rst_d;
            rid_q   <= rid_d;
            raddr_q <= raddr_d;
            rlen_q  <= rlen_d;
            rcnt_q  <= rcnt_d;
            rbur_q  <= rbur_d;
            rerr_q  <= rerr_d;
            rdata_q <= rdata_d;
            rlast_q <= rlast_d;
            rresp_q <= rresp_d;
        end
    end

    assign MEM.ARREADY = (rst_q == R_IDLE) && rdy_en_q;
    assign MEM.RVALID  = (rst_q == R_DATA);
    assign MEM.RID     = rid_q;
    assign MEM.RDATA   = rdata_q;
    assign MEM.RRESP   = rresp_q;
    assign MEM.RLAST   = rlast_q;
endmodule

// File: doc/axi4_slv_mem.md
AXI4_SLV_MEM -- requirements
Module: axi4_slv_mem

Interface
REQ-001 Parameter DW, default 64, data width in bits; legal values 32, 64, 128.
REQ-002 Parameter AW, default 14, word-address width; memory depth is 2^AW words of DW bits.
REQ-003 Parameter IDW, default 8, AXI ID width.
REQ-004 Parameter BASE, default 32'h8000_0000, byte base address of the memory window.
REQ-005 CLK  input  1  single clock; all state changes on its rising edge.
REQ-006 RSTn  input  1  reset, asynchronous assert, active-low.
REQ-007 MEM_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  input  IDW/32/8/3/2/1  write address channel; MEM_AWREADY output 1.
REQ-008 MEM_WDATA/WSTRB/WLAST/WVALID  input  DW/DW/8/1/1  write data channel; MEM_WREADY output 1.
REQ-009 MEM_BID/BRESP/BVALID  output  IDW/2/1  write response; MEM_BREADY input 1.
REQ-010 MEM_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  input  IDW/32/8/3/2/1  read address channel; MEM_ARREADY output 1.
REQ-011 MEM_RID/RDATA/RRESP/RLAST/RVALID  output  IDW/DW/2/1/1  read data channel; MEM_RREADY input 1.

Function
REQ-012 Read and write engines SHALL be fully independent and run concurrently; neither blocks the other.
REQ-013 Write FSM states W_IDLE, W_DATA, W_RESP: AWREADY=1 only in W_IDLE; AW handshake latches ID, addr, len, burst, error flag -> W_DATA; WREADY=1 only in W_DATA; beat with WLAST=1 or beat count == len -> W_RESP; BVALID=1 in W_RESP; BVALID&BREADY -> W_IDLE.
REQ-014 Read FSM states R_IDLE, R_FETCH, R_DATA: ARREADY=1 only in R_IDLE; AR handshake -> R_FETCH (one-cycle SRAM read); R_FETCH -> R_DATA with RVALID=1; RVALID&RREADY on non-last beat -> R_FETCH at next address; on last beat -> R_IDLE.
REQ-015 RDATA, RID, RRESP, RLAST SHALL remain stable while RVALID=1 and RREADY=0.
REQ-016 RLAST SHALL be 1 exactly on beat index == ARLEN; beats per burst = AxLEN+1 (1..256).
REQ-017 Burst addressing: FIXED(00) holds address; INCR(01) adds DW/8 per beat; WRAP(10) increments and wraps at boundary (AxLEN+1)*DW/8 aligned down from start address; reserved(11) treated as INCR with SLVERR.
REQ-018 Word index = (addr - BASE) >> log2(DW/8), truncated to AW bits after range check.
REQ-019 A burst SHALL be flagged SLVERR (2'b10) if: AxSIZE != log2(DW/8); WRAP with AxLEN not in {1,3,7,15}; any beat address outside [BASE, BASE + 2^AW*DW/8); AxBURST==11.
REQ-020 Error write bursts SHALL accept all beats but not modify memory; BRESP=10; otherwise BRESP=00.
REQ-021 Error read bursts SHALL return all AxLEN+1 beats with RDATA=0, RRESP=10; otherwise RRESP=00.
REQ-022 Writes SHALL honour WSTRB per byte; strobe-0 bytes unchanged.
REQ-023 Write with early WLAST (before len beats) SHALL end the burst, report SLVERR; WLAST missing at beat len SHALL still end the burst with SLVERR.
REQ-024 Same-cycle read fetch and write commit to one word: read returns pre-write data.
REQ-025 BID/RID SHALL equal the AWID/ARID latched at the address handshake.
REQ-026 Throughput: one W beat per cycle; one R beat every 2 cycles (fetch + data).
REQ-027 Memory array contents are not reset.

Reset
REQ-028 RSTn low SHALL immediately force both FSMs to IDLE: AWREADY=0, WREADY=0, BVALID=0, ARREADY=0, RVALID=0, RLAST=0, BRESP=RRESP=00, BID=RID=0, RDATA=0; in-flight bursts are abandoned.
REQ-029 AWREADY and ARREADY SHALL rise on the first clock edge after RSTn deasserts.

Verification
REQ-030 INCR write AWADDR=BASE+0x40, AWLEN=3, DW=64, WSTRB=FF, data 1..4, then INCR read same -> BRESP=00; RDATA 1,2,3,4, RLAST on 4th, RRESP=00.
REQ-031 WRAP read ARADDR=BASE+0x18, ARLEN=3, DW=64 -> beat addresses 0x18,0x00,0x08,0x10 relative to BASE.
REQ-032 Write ARADDR/AWADDR=BASE-8 or AWSIZE=2 with DW=64 -> BRESP=10, memory unchanged; read same -> RRESP=10, RDATA=0 on every beat.
REQ-033 WSTRB=0x0F over word 0xFFFF_FFFF_FFFF_FFFF with data 0 -> readback 0xFFFF_FFFF_0000_0000.
REQ-034 Concurrent 16-beat write and 16-beat read to different regions with RREADY toggling randomly -> both complete, RDATA stable under stall, IDs echoed correctly.
REQ-035 RSTn pulsed low mid-burst (beat 2 of 8) -> all valid/ready outputs 0 asynchronously; new burst after release completes normally.
